chunked_addsub: RTL and testbench
=================================

# chunked_addsub

Parametrised multi-cycle adder/subtractor, the sequential successor of the team's 4-bit combinational adder. It processes WIDTH-bit operands CHUNK bits per clock with a registered carry. This trades latency for a short carry chain at large widths. It sits behind a valid/ready handshake on both sides, so it drops into streaming datapaths with back-pressure, and it reports carry-out and signed overflow.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of CHUNK, ≥ 1
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH
- Derived: NCH = WIDTH/CHUNK (chunks per operation)

Ports:
- clk  in  1  single clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands/mode valid
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A (unsigned or two's complement)
- b  in  WIDTH  operand B
- sub  in  1  0: A+B, 1: A−B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry out of MSB (for subtract: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow

## Operation
- FSM states: IDLE, BUSY, DONE. Reset → IDLE.
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, chunk index=0, carry reg=0.
- in_ready = (state==IDLE); out_valid = (state==DONE). Both are pure decodes of the state register.
- IDLE: on in_valid && in_ready, register the following and go to BUSY:
  - a
  - b_eff = sub ? ~b : b
  - carry = sub
  - index = 0
  - sum is cleared to 0.
- BUSY: each cycle, compute {c, s} = a[k] + b_eff[k] + carry on chunk k = index. Chunk k spans bits [k*CHUNK +: CHUNK], LSB first.
  - Write s into sum[k]; carry ← c; index++.
  - On the cycle processing k = NCH−1, also latch:
    - cout ← c
    - ovf ← (a_msb == b_eff_msb) && (s_msb != a_msb)
  - Then go to DONE.
- DONE: sum/cout/ovf held stable while out_valid && !out_ready. On out_ready go to IDLE. Outputs keep their values until the next acceptance clears sum.
- No new operation is accepted in BUSY or DONE. Inputs a/b/sub are ignored outside the acceptance cycle.
- rst asserted at any time, including mid-BUSY or in DONE: immediate return to reset values. The partial result is discarded and no out_valid pulse is produced.
- CHUNK == WIDTH is legal: a single BUSY cycle.

## Timing
- Acceptance at clock edge E0. BUSY edges are E1..E_NCH. out_valid goes high after E_NCH, so latency is NCH cycles from accept to out_valid.
- Defaults (16/4): out_valid 4 cycles after the accept edge.
- Output transfer on the edge where out_valid && out_ready. in_ready rises in the following cycle.
- Minimum issue interval NCH+2 cycles with out_ready held high:
  - 1 accept cycle
  - NCH BUSY cycles
  - 1 DONE cycle
- No combinational path from in_valid/out_ready to any output.

## Test plan
(WIDTH=16, CHUNK=4 unless stated)
- Add 0x1234 + 0x1111, out_ready=1 → sum=0x2345, cout=0, ovf=0. out_valid exactly 4 cycles after accept; in_ready=0 from accept until the cycle after DONE.
- Carry chain across all chunks, 0xFFFF + 0x0001 → sum=0x0000, cout=1, ovf=0. Then 0x7FFF + 0x0001 → sum=0x8000, cout=0, ovf=1.
- Subtract 0x0005 − 0x0007 → sum=0xFFFE, cout=0, ovf=0. Then 0x8000 − 0x0001 → sum=0x7FFF, cout=1, ovf=1.
- Back-pressure: hold out_ready=0 for 3 cycles in DONE while driving a new in_valid with changing a/b.
  - sum/cout/ovf stay stable; in_ready stays 0; the second operation is not accepted.
  - After out_ready=1 it is accepted in IDLE and computed correctly.
- Reset mid-operation: assert rst two cycles after accept.
  - All outputs go to reset values at once and in_ready=1.
  - No out_valid occurs; the next operation 0x0001+0x0001 → 0x0002.
- Parameter sweep over these configurations:
  - CHUNK=16 (latency 1)
  - CHUNK=1 (latency 16)
  - WIDTH=4, CHUNK=2: exhaustive 256 add and 256 sub cases checked against a reference model (sum, cout, ovf).

Source files
------------

// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock with a registered carry,
// behind valid/ready handshakes on both sides; reports carry-out and signed overflow.
module chunked_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg, sum_next;
    logic             carry_reg, cout_reg, ovf_reg;
    logic [IW-1:0]    idx_reg;
    logic [CHUNK-1:0] a_ch [NCH];
    logic [CHUNK-1:0] b_ch [NCH];
    logic [CHUNK:0]   chunk_sum;
    logic             last_chunk;
    logic             accept;

    // Slice the operands into chunks and merge the fresh chunk result into the sum.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
            assign a_ch[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_ch[gi] = b_reg[gi*CHUNK +: CHUNK];
            assign sum_next[gi*CHUNK +: CHUNK] = (idx_reg == IW'(gi)) ?
                chunk_sum[CHUNK-1:0] : sum_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign chunk_sum  = {1'b0, a_ch[idx_reg]} + {1'b0, b_ch[idx_reg]} + {{CHUNK{1'b0}}, carry_reg};
    assign last_chunk = (idx_reg == IW'(NCH - 1));
    assign accept     = in_valid && (state_reg == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)   state_next = BUSY;
            BUSY:    if (last_chunk) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
    end

    // Subtraction is A + ~B + 1: the inverted operand is stored and the carry seeded with 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            idx_reg   <= '0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub;
            sum_reg   <= '0;
            idx_reg   <= '0;
        end else if (state_reg == BUSY) begin
            sum_reg   <= sum_next;
            carry_reg <= chunk_sum[CHUNK];
            idx_reg   <= last_chunk ? '0 : idx_reg + 1'b1;
            if (last_chunk) begin
                cout_reg <= chunk_sum[CHUNK];
                ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                            (chunk_sum[CHUNK-1] != a_reg[WIDTH-1]);
            end
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;
endmodule

// File: tb/tb_chunked_addsub.sv
// Scoreboard bench for chunked_addsub: directed 16/4 tests plus a sweep over
// 16/16, 16/1 and an exhaustive 4/2 configuration.
`timescale 1ns/1ps
module tb_chunked_addsub;
    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, sub, cout, ovf;
    logic [15:0] a, b, sum;
    int          errors = 0;
    int          checks = 0;
    bit          main_done = 1'b0;
    int          gdone_cnt = 0;
    exp_t        exp_q[$];

    logic [15:0] tv_a [8] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0000, 16'h8000, 16'h7FFF};
    logic [15:0] tv_b [8] = '{16'h1111, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0000, 16'h8000, 16'h8000};
    logic        tv_s [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    chunked_addsub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end else
            $display("ok   %s: %h", name, got);
    endtask

    // Monitor: every output transfer is compared against the head of the queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'(sum), 32'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result{sum,cout,ovf}", {14'b0, sum, cout, ovf}, {14'b0, e.s, e.c, e.o});
            end
        end
    end

    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                         input logic [15:0] es, input logic ec, input logic eo, input bit push);
        int n = 0;
        @(posedge clk); #1;
        a = ta; b = tb_; sub = ts; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("issue_timeout", 32'(n), 0);
        if (push) exp_q.push_back('{s: es, c: ec, o: eo});
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int lat;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_sum_cout_ovf", {14'b0, sum, cout, ovf}, 0);
        rst = 1'b0;

        // Basic add with latency and in_ready profile.
        issue(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1);
        chk("in_ready_after_accept", 32'(in_ready), 0);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!out_valid && lat < 50);
        chk("latency_16_4", 32'(lat), 4);
        chk("in_ready_in_done", 32'(in_ready), 0);
        @(posedge clk); #1;
        chk("in_ready_after_done", 32'(in_ready), 1);
        chk("out_valid_after_done", 32'(out_valid), 0);
        wait_drain();

        issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1); wait_drain();
        issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1); wait_drain();
        issue(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1); wait_drain();
        issue(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1); wait_drain();

        // Back-pressure: result held while a competing request is presented.
        out_ready = 1'b0;
        issue(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_hold{sum,cout,ovf}", {14'b0, sum, cout, ovf}, {14'b0, 16'h1000, 1'b0, 1'b0});
        end
        a = 16'h0003; b = 16'h0004; sub = 1'b1;
        exp_q.push_back('{s: 16'hFFFF, c: 1'b0, o: 1'b0});
        out_ready = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!in_ready && lat < 50);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain();

        // Reset two cycles after accept discards the operation.
        issue(16'hAAAA, 16'h1111, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 1);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_sum_cout_ovf", {14'b0, sum, cout, ovf}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        issue(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
        wait_drain();
        main_done = 1'b1;
    end

    // Parameter sweep: 16/16, 16/1 with directed vectors; 4/2 exhaustive.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
            localparam int W = (gi == 2) ? 4 : 16;
            localparam int C = (gi == 0) ? 16 : (gi == 1) ? 1 : 2;
            logic         g_rst, g_iv, g_ir, g_ov, g_sub, g_cout, g_ovf;
            logic [W-1:0] g_a, g_b, g_sum;
            logic [W+1:0] g_q[$];

            chunked_addsub #(.WIDTH(W), .CHUNK(C)) dut_g (
                .clk(clk), .rst(g_rst), .in_valid(g_iv), .in_ready(g_ir),
                .a(g_a), .b(g_b), .sub(g_sub), .out_valid(g_ov), .out_ready(1'b1),
                .sum(g_sum), .cout(g_cout), .ovf(g_ovf)
            );

            always @(negedge clk) begin
                if (!g_rst && g_ov) begin
                    if (g_q.size() == 0) chk($sformatf("cfg%0d_unexpected_out", gi), 32'(g_sum), 32'hDEAD);
                    else chk($sformatf("cfg%0d_result", gi), 32'({g_sum, g_cout, g_ovf}), 32'(g_q.pop_front()));
                end
            end

            initial begin
                int           total, lat, n;
                logic [W-1:0] x, y, rs;
                logic         s, ro;
                logic [W:0]   full;
                g_rst = 1'b1; g_iv = 1'b0; g_a = '0; g_b = '0; g_sub = 1'b0;
                repeat (3) @(posedge clk);
                #1 g_rst = 1'b0;
                total = (W == 4) ? 512 : 8;
                for (int i = 0; i < total; i++) begin
                    if (W == 4) begin
                        x = W'(i % 16); y = W'((i / 16) % 16); s = (i >= 256);
                    end else begin
                        x = tv_a[i][W-1:0]; y = tv_b[i][W-1:0]; s = tv_s[i];
                    end
                    // Reference: modular add with sign-rule overflow on the original operands.
                    full = {1'b0, x} + {1'b0, (s ? ~y : y)} + (W+1)'(s);
                    rs   = full[W-1:0];
                    ro   = s ? ((x[W-1] != y[W-1]) && (rs[W-1] != x[W-1]))
                             : ((x[W-1] == y[W-1]) && (rs[W-1] != x[W-1]));
                    n = 0;
                    while (!g_ir && n < 100) begin
                        @(posedge clk); #1; n++;
                    end
                    g_a = x; g_b = y; g_sub = s; g_iv = 1'b1;
                    g_q.push_back({rs, full[W], ro});
                    @(posedge clk); #1;
                    g_iv = 1'b0;
                    lat = 0;
                    do begin
                        @(posedge clk); #1; lat++;
                    end while (!g_ov && lat < 40);
                    if (i < 3) chk($sformatf("cfg%0d_latency", gi), 32'(lat), 32'(W / C));
                end
                repeat (4) @(posedge clk);
                chk($sformatf("cfg%0d_drain", gi), 32'(g_q.size()), 0);
                gdone_cnt++;
            end
        end
    endgenerate

    initial begin
        wait (main_done && gdone_cnt == 3);
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        checks++;
        $display("FAIL global_timeout: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
